// File: rtl/bus_grant_encoder_if.sv
// Bus-grant handshake bundle: request lines and owner release in, registered grant out.
// The owner-finished strobe is named rel because "release" is a reserved word.
interface bus_grant_encoder_if #(
    parameter int N    = 16,
    parameter int IDXW = 4
);
    logic [N-1:0]    req;
    logic            rel;
    logic [IDXW-1:0] grant_idx;
    logic [N-1:0]    grant_onehot;
    logic            grant_valid;
    logic            multi_req;

    // master: the request side; slave: the encoder itself
    modport master (
        output req, rel,
        input  grant_idx, grant_onehot, grant_valid, multi_req
    );

    modport slave (
        input  req, rel,
        output grant_idx, grant_onehot, grant_valid, multi_req
    );
endinterface

// File: rtl/bus_grant_encoder.sv
// Round-robin 16-to-4 bus-grant encoder: arbitrates the request lines, registers the
// winner as an index plus one-hot select, and holds it until the owner lets go.
module bus_grant_encoder #(
    parameter int N    = 16,
    parameter int IDXW = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    bus_grant_encoder_if.slave    bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [IDXW-1:0] ptr, ptr_nxt;
    logic [IDXW-1:0] idx_q, idx_nxt;
    logic [N-1:0]    onehot_q, onehot_nxt;
    logic            valid_q, valid_nxt;
    logic            multi_q, multi_nxt;

    logic            found;
    logic [IDXW-1:0] win;
    logic [IDXW-1:0] cand;
    logic            multi_now;
    logic            owner_exit;

    // Rotating priority scan starting at ptr; the first set bit wins.
    // NOTE: every always_comb output is given a default before any branch so no latch is inferred.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr + IDXW'(i);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // More than one bit set: clearing the lowest set bit leaves something behind.
    assign multi_now  = |(bus.req & (bus.req - N'(1)));
    assign owner_exit = bus.rel || !bus.req[idx_q];

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        idx_nxt    = idx_q;
        onehot_nxt = onehot_q;
        valid_nxt  = valid_q;
        multi_nxt  = multi_q;
        unique case (state)
            IDLE: begin
                if (found) begin
                    idx_nxt    = win;
                    onehot_nxt = N'(1) << win;
                    valid_nxt  = 1'b1;
                    multi_nxt  = multi_now;
                    state_nxt  = GRANT;
                end
            end
            GRANT: begin
                // Release and owner drop together still make a single exit.
                if (owner_exit) begin
                    valid_nxt  = 1'b0;
                    onehot_nxt = '0;
                    ptr_nxt    = idx_q + IDXW'(1);
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            ptr      <= '0;
            idx_q    <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            multi_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            idx_q    <= idx_nxt;
            onehot_q <= onehot_nxt;
            valid_q  <= valid_nxt;
            multi_q  <= multi_nxt;
        end
    end

    assign bus.grant_idx    = idx_q;
    assign bus.grant_onehot = onehot_q;
    assign bus.grant_valid  = valid_q;
    assign bus.multi_req    = multi_q;

endmodule

// File: tb/tb_bus_grant_encoder.sv
// Directed bench for bus_grant_encoder: hand-computed grants for reset, fairness,
// pointer wrap, owner drop, simultaneous exit causes and mid-grant reset.
module tb_bus_grant_encoder;

    logic clk = 1'b0;
    logic clr;
    int   total = 0;
    int   bad   = 0;

    bus_grant_encoder_if #(.N(16), .IDXW(4)) bus ();

    bus_grant_encoder #(.N(16), .IDXW(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_grant(input string tag, input logic [3:0] idx, input logic multi);
        check({tag, " valid"},  32'(bus.grant_valid),  32'(1'b1));
        check({tag, " idx"},    32'(bus.grant_idx),    32'(idx));
        check({tag, " onehot"}, 32'(bus.grant_onehot), 32'(16'h0001 << idx));
        check({tag, " multi"},  32'(bus.multi_req),    32'(multi));
    endtask

    task automatic check_idle(input string tag, input logic [3:0] idx);
        check({tag, " valid"},  32'(bus.grant_valid),  32'(1'b0));
        check({tag, " onehot"}, 32'(bus.grant_onehot), 32'(16'h0000));
        check({tag, " idx"},    32'(bus.grant_idx),    32'(idx));
    endtask

    initial begin
        automatic logic [3:0] rr_seq [5] = '{4'd0, 4'd4, 4'd15, 4'd0, 4'd4};

        clr     = 1'b1;
        bus.req = '0;
        bus.rel = 1'b0;
        #1;

        // Reset and single request
        step();
        step();
        check_idle("reset", 4'd0);
        check("reset multi", 32'(bus.multi_req), 32'(1'b0));
        clr     = 1'b0;
        bus.req = 16'h0020;
        step();
        check_grant("single", 4'd5, 1'b0);
        bus.rel = 1'b1;
        step();
        check_idle("single rel", 4'd5);
        bus.rel = 1'b0;
        bus.req = '0;
        step();
        // release while idle does nothing
        bus.rel = 1'b1;
        step();
        check_idle("idle rel", 4'd5);
        bus.rel = 1'b0;

        // Round-robin fairness on 16'h8011 from a reset pointer
        clr = 1'b1;
        step();
        clr     = 1'b0;
        bus.req = 16'h8011;
        for (int k = 0; k < 5; k++) begin
            step();
            check_grant($sformatf("rr%0d", k), rr_seq[k], 1'b1);
            bus.rel = 1'b1;
            step();
            check_idle($sformatf("rr%0d gap", k), rr_seq[k]);
            bus.rel = 1'b0;
        end
        bus.req = '0;

        // Pointer wrap: after owner 15 exits, ptr is 0 so bit 0 beats bit 1
        clr = 1'b1;
        step();
        clr     = 1'b0;
        bus.req = 16'h8000;
        step();
        check_grant("wrap 15", 4'd15, 1'b0);
        bus.rel = 1'b1;
        step();
        check_idle("wrap rel", 4'd15);
        bus.rel = 1'b0;
        bus.req = 16'h0003;
        step();
        check_grant("wrap next", 4'd0, 1'b1);
        bus.rel = 1'b1;
        bus.req = '0;
        step();
        bus.rel = 1'b0;

        // Owner drop; other request changes ignored while granted
        clr = 1'b1;
        step();
        clr     = 1'b0;
        bus.req = 16'h0004;
        step();
        check_grant("drop own", 4'd2, 1'b0);
        bus.req = 16'h0104;
        step();
        check_grant("drop hold1", 4'd2, 1'b0);
        step();
        check_grant("drop hold2", 4'd2, 1'b0);
        bus.req = 16'h0100;
        step();
        check_idle("drop exit", 4'd2);
        step();
        check_grant("drop next", 4'd8, 1'b0);
        bus.req = '0;
        step();
        check_idle("drop8 exit", 4'd8);

        // Release and owner drop on the same edge: one exit, ptr 0 -> 1
        clr = 1'b1;
        step();
        clr     = 1'b0;
        bus.req = 16'h0007;
        step();
        check_grant("simul own", 4'd0, 1'b1);
        bus.rel = 1'b1;
        bus.req = 16'h0006;
        step();
        check_idle("simul exit", 4'd0);
        bus.rel = 1'b0;
        step();
        check_grant("simul next", 4'd1, 1'b1);
        bus.rel = 1'b1;
        bus.req = '0;
        step();
        bus.rel = 1'b0;

        // Reset mid-grant
        bus.req = 16'h0200;
        step();
        check_grant("mid own", 4'd9, 1'b0);
        bus.req = 16'hFFFF;
        clr     = 1'b1;
        step();
        check_idle("mid clr", 4'd0);
        check("mid clr multi", 32'(bus.multi_req), 32'(1'b0));
        clr = 1'b0;
        step();
        check_grant("mid after", 4'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bus_grant_encoder.md
# bus_grant_encoder

Sequential 16-to-4 bus-grant encoder: the inverse of the bus-select decoder that turns a 4-bit index into a one-hot 16-bit select. Sixteen bus sources raise request lines. The block arbitrates round-robin among them and registers the winner as a 4-bit index plus a matching one-hot select. It holds that grant until the owner releases it. It sits between the datapath register request lines and the bus multiplexer select.

## Interface
- N, 16, number of request lines (fixed at 16 for this revision).
- IDXW, 4, width of the encoded index, log2(N).

- clk  in  1  rising-edge clock.
- clr  in  1  synchronous, active-high reset.
- req  in  16  request vector; bit k high = source k wants the bus; multiple bits may be high.
- release  in  1  current owner is finished; sampled only in GRANT.
- grant_idx  out  4  registered index of the current owner.
- grant_onehot  out  16  registered one-hot form of grant_idx; all zeros when no grant.
- grant_valid  out  1  high while a grant is held.
- multi_req  out  1  registered; high if more than one req bit was set on the cycle the current grant was issued.

## Operation
- Internal state:
  - 4-bit round-robin pointer `ptr`, the highest-priority candidate.
  - FSM with states IDLE and GRANT.
- IDLE:
  - If req == 0, stay in IDLE with outputs unchanged at their idle values.
  - Otherwise, select the first set bit scanning ptr, ptr+1, …, 15, 0, …, ptr-1 (mod 16). Load grant_idx, grant_onehot = 1 << idx, grant_valid = 1 and multi_req = (popcount(req) > 1). Go to GRANT.
- GRANT:
  - grant_idx, grant_onehot and multi_req are frozen.
  - Changes on other req bits are ignored.
  - Exit when release = 1, or when req[grant_idx] = 0 (owner dropped its request).
  - On exit: grant_valid = 0, grant_onehot = 0, ptr = grant_idx + 1 (mod 16, so 15 wraps to 0), go to IDLE. grant_idx keeps its last value.
- If release and an owner drop occur in the same cycle, the block performs a single exit.
- The pointer advances only on exit, never on issue.
- clr has priority over every other input on any cycle, including mid-grant:
  - FSM = IDLE, ptr = 0.
  - grant_idx = 0, grant_onehot = 16'h0000, grant_valid = 0, multi_req = 0.
- Invariant: grant_onehot == (grant_valid ? 1 << grant_idx : 0) on every cycle.

## Timing
- Reset values: grant_idx = 4'h0, grant_onehot = 16'h0000, grant_valid = 0, multi_req = 0.
- Issue latency: req nonzero at edge n in IDLE gives grant_valid = 1 after edge n, visible in cycle n+1.
- Release latency: release sampled at edge m gives grant_valid = 0 in cycle m+1.
- After any exit, IDLE lasts at least one cycle, so the earliest next grant is visible in cycle m+2. This guarantees one dead bus cycle between owners.
- A grant lasts at least one cycle. release asserted in IDLE has no effect.
- All outputs are registered; no combinational path from req or release to any output.

## Test plan
- Reset and single request:
  - Assert clr for 2 cycles, check all outputs are zero.
  - Drive req = 16'h0020; next cycle requires grant_idx = 5, grant_onehot = 16'h0020, grant_valid = 1, multi_req = 0.
  - Pulse release; next cycle requires grant_valid = 0 and grant_onehot = 0.
- Round-robin fairness: hold req = 16'h8011 and pulse release one cycle after each grant.
  - Required grant sequence: 0, 4, 15, 0, 4, with at least one idle cycle between grants.
  - multi_req = 1 on every grant.
- Pointer wrap: after reset, grant and release index 15 using req = 16'h8000, then drive req = 16'h0003.
  - Required next grant_idx = 0 (ptr wrapped to 0), not 1.
- Owner drop and ignored requests: grant index 2 with req = 16'h0004.
  - Change req to 16'h0100; grant_idx must stay 2 until req[2] = 0 is sampled.
  - grant_valid then goes low for one cycle, followed by grant_idx = 8.
- Simultaneous exit causes: assert release in the same cycle req[owner] drops.
  - Only one exit occurs: ptr advances once and grant_valid stays low exactly one cycle before the next grant.
- Reset mid-grant: with grant_idx = 9 held, assert clr with req = 16'hFFFF.
  - Next cycle all outputs must be zero.
  - After clr deasserts, the first grant must be index 0 (ptr reset).
